// File: rtl/huffman_decoder_pkg.sv
// huffman_dec_pkg: canonical code tables and symbol ROM shared by the decoder
package huffman_dec_pkg;
  localparam int MAX_LEN_DEF = 16;
  localparam int SYM_W_DEF = 8;
  localparam int NSYM = 4;
  localparam int SYM_AW = $clog2(NSYM);
  typedef logic [15:0] tbl_t [1:16];
  localparam tbl_t COUNT = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0,
                             16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
  localparam tbl_t FIRST = '{16'd0, 16'd2, 16'd6, 16'd14, 16'd0, 16'd0, 16'd0, 16'd0,
                             16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
  localparam tbl_t BASE  = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd4, 16'd4, 16'd4,
                             16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 16'd4};
  localparam logic [7:0] SYMS [NSYM] = '{8'h00, 8'h01, 8'h02, 8'h03};
endpackage

// File: rtl/huffman_decoder_if.sv
// huffman_decoder_if: byte-in / symbol-out handshake bundle
interface huffman_decoder_if #(parameter int SYM_W = 8);
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [SYM_W-1:0] out_sym;
  logic [4:0] out_len;
  logic out_valid;
  logic out_ready;
  logic err;
  modport slave (input in_data, in_valid, out_ready, output in_ready, out_sym, out_len, out_valid, err);
  modport master (output in_data, in_valid, out_ready, input in_ready, out_sym, out_len, out_valid, err);
endinterface

// File: rtl/huffman_canon_lookup.sv
// huffman_canon_lookup: combinational canonical match of an l-bit code c
module huffman_canon_lookup
  import huffman_dec_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int SYM_W = SYM_W_DEF
) (
  input  logic [MAX_LEN-1:0] c,
  input  logic [4:0] l,
  output logic hit,
  output logic [SYM_W-1:0] sym
);
  logic [MAX_LEN-1:0] off;
  logic [31:0] idx;
  always_comb begin
    off = c - MAX_LEN'(FIRST[l]);
    hit = 32'(off) < 32'(COUNT[l]);
    idx = 32'(BASE[l]) + 32'(off);
    sym = idx < 32'(NSYM) ? SYM_W'(SYMS[idx[SYM_AW-1:0]]) : '0;
  end
endmodule

// File: rtl/huffman_decoder.sv
// huffman_decoder: MSB-first bit-serial canonical Huffman decoder, one bit per clock
module huffman_decoder
  import huffman_dec_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int SYM_W = SYM_W_DEF
) (
  input logic clk,
  input logic rst,
  huffman_decoder_if.slave bus
);
  logic [7:0] sh;
  logic [3:0] bcnt;
  logic [MAX_LEN-1:0] code;
  logic [4:0] len;
  logic [MAX_LEN-1:0] c;
  logic [4:0] l;
  logic step, hit;
  logic [SYM_W-1:0] sym;
  assign bus.in_ready = bcnt == 4'd0 && !bus.err;
  // a pending symbol the sink refuses freezes the bit stream
  assign step = bcnt != 4'd0 && !bus.err && !(bus.out_valid && !bus.out_ready);
  assign c = MAX_LEN'({code, sh[7]});
  assign l = len + 5'd1;
  huffman_canon_lookup #(.MAX_LEN(MAX_LEN), .SYM_W(SYM_W)) lookup (.c, .l, .hit, .sym);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh <= '0;
      bcnt <= '0;
      code <= '0;
      len <= '0;
      bus.out_sym <= '0;
      bus.out_len <= '0;
      bus.out_valid <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        sh <= bus.in_data;
        bcnt <= 4'd8;
      end else if (step) begin
        sh <= sh << 1;
        bcnt <= bcnt - 4'd1;
      end
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
      if (step) begin
        if (hit) begin
          bus.out_sym <= sym;
          bus.out_len <= l;
          bus.out_valid <= 1'b1;
          code <= '0;
          len <= '0;
        end else if (l < 5'(MAX_LEN)) begin
          code <= c;
          len <= l;
        end else bus.err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_huffman_decoder.sv
// tb_huffman_decoder: directed vectors against the 4-symbol test code (A=0, B=10, C=110, D=1110)
module tb_huffman_decoder;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  logic [12:0] rx[$];
  logic [12:0] ex[$];
  huffman_decoder_if #(.SYM_W(8)) bus ();
  huffman_decoder #(.MAX_LEN(4), .SYM_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (!rst && bus.out_valid && bus.out_ready) rx.push_back({bus.out_len, bus.out_sym});
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end
  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask
  task send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.in_data = b;
    bus.in_valid = 1;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1 bus.in_valid = 0;
  endtask
  task add(input logic [7:0] s, input logic [4:0] len);
    ex.push_back({len, s});
  endtask
  task drain(input string tag);
    int k = 0;
    while (rx.size() < ex.size() && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (12) @(negedge clk);
    check({tag, "_count"}, rx.size(), ex.size());
    foreach (ex[i]) if (i < rx.size()) check(tag, 32'(rx[i]), 32'(ex[i]));
    rx.delete();
    ex.delete();
  endtask
  task do_reset();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    rx.delete();
  endtask
  initial begin
    int n;
    bus.in_data = 0;
    bus.in_valid = 0;
    bus.out_ready = 1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_sym", 32'(bus.out_sym), 0);
    check("rst_out_len", 32'(bus.out_len), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    send(8'h00);
    @(negedge clk);
    check("first_lat_lo", 32'(bus.out_valid), 0);
    @(negedge clk);
    check("first_lat_hi", 32'(bus.out_valid), 1);
    for (int i = 0; i < 8; i++) add(8'h00, 5'd1);
    drain("zeros");
    send(8'h58);
    add(8'h00, 5'd1); add(8'h01, 5'd2); add(8'h02, 5'd3); add(8'h00, 5'd1); add(8'h00, 5'd1);
    drain("mix58");
    send(8'h01);
    send(8'hC0);
    for (int i = 0; i < 7; i++) add(8'h00, 5'd1);
    add(8'h03, 5'd4);
    for (int i = 0; i < 5; i++) add(8'h00, 5'd1);
    drain("span");
    send(8'hF0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("err_early", 32'(bus.err), 0);
    end
    @(negedge clk);
    check("err_4th", 32'(bus.err), 1);
    repeat (10) @(negedge clk);
    check("err_sticky", 32'(bus.err), 1);
    check("err_in_ready", 32'(bus.in_ready), 0);
    check("err_no_sym", rx.size(), 0);
    do_reset();
    check("err_cleared", 32'(bus.err), 0);
    bus.out_ready = 0;
    send(8'h58);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_valid", 32'(bus.out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_sym", 32'(bus.out_sym), 0);
      check("stall_len", 32'(bus.out_len), 1);
    end
    check("stall_bcnt", 32'(dut.bcnt), 7);
    bus.out_ready = 1;
    add(8'h00, 5'd1); add(8'h01, 5'd2); add(8'h02, 5'd3); add(8'h00, 5'd1); add(8'h00, 5'd1);
    drain("stall58");
    send(8'hEE);
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_valid", 32'(bus.out_valid), 0);
    rst = 1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 0);
    check("arst_out_sym", 32'(bus.out_sym), 0);
    check("arst_out_len", 32'(bus.out_len), 0);
    check("arst_err", 32'(bus.err), 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 1);
    check("post_rst_len", 32'(dut.len), 0);
    rx.delete();
    send(8'h00);
    for (int i = 0; i < 8; i++) add(8'h00, 5'd1);
    drain("after_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/huffman_decoder.md
# huffman_decoder

Canonical Huffman decoder: the inverse of the team's Huffman encoder data path. It accepts the encoded bitstream as bytes, consumes it MSB-first at one bit per clock, and emits one decoded symbol per completed codeword over a valid/ready handshake. It sits between the byte-stream source and the symbol sink, and its output is compared against the encoder reference model's input stimulus.

## Interface
- MAX_LEN, default 16: maximum codeword length in bits.
- SYM_W, default 8: symbol width.
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- in_data, in, 8: encoded byte; bit 7 is consumed first.
- in_valid, in, 1: in_data valid.
- in_ready, out, 1: byte accepted when in_valid && in_ready.
- out_sym, out, SYM_W: decoded symbol.
- out_len, out, 5: length of the codeword that produced out_sym.
- out_valid, out, 1: out_sym/out_len valid.
- out_ready, in, 1: sink accepts the symbol when out_valid && out_ready.
- err, out, 1: sticky invalid-code flag.

## Operation
- Registers:
  - byte shift register sh[7:0] and bits-left counter bcnt[3:0];
  - code accumulator code[MAX_LEN-1:0] and its length len.
- in_ready = (bcnt == 0) && !err. On accept: sh <= in_data, bcnt <= 8.
- Bit step. It occurs when bcnt != 0 && !err && !(out_valid && !out_ready).
  - b = sh[7]; sh <= sh << 1; bcnt--.
  - c = {code, b}; l = len + 1.
- Canonical match at length l:
  - The match holds when (c - FIRST[l]) < COUNT[l], using unsigned MAX_LEN-bit arithmetic.
  - Symbol = SYMS[BASE[l] + c - FIRST[l]].
- On match: out_sym <= symbol, out_len <= l, out_valid <= 1, code <= 0, len <= 0.
- No match and l < MAX_LEN: code <= c, len <= l.
- No match and l == MAX_LEN: err <= 1.
  - The decoder halts: in_ready = 0, and no further bit steps until reset.
  - out_valid keeps any already-pending symbol until it is accepted.
- Output handshake:
  - out_valid clears on out_valid && out_ready, unless a new match is produced in the same cycle.
  - If a new match coincides, out_valid stays 1 and the new symbol loads.
- Codewords may span byte boundaries. code/len persist across bytes.
- States (implicit from bcnt/out_valid/err): IDLE (bcnt = 0), SHIFT, STALL (output pending, not ready), ERR.
- Reset values (asynchronous, immediate):
  - all outputs 0, except in_ready = 1 after reset;
  - sh, bcnt, code, len = 0.

## Timing
- Byte accepted at edge t0; its first bit is stepped at edge t0+1.
- Last bit of a codeword stepped at edge t → out_valid high after edge t (visible cycle t+1).
- With out_ready = 1: a full 1-bit-per-clock throughput; a byte drains in 8 clocks.
- The next byte is accepted at the edge after the byte's last bit steps, so there is a 1-clock bubble per byte.
- With out_ready = 0 and out_valid = 1: bit steps freeze and out_sym/out_len hold stable.
- Reset mid-codeword: partial code is discarded, and no symbol is emitted.

## Structure
- Package huffman_dec_pkg holds:
  - MAX_LEN/SYM_W defaults;
  - COUNT[1..MAX_LEN], FIRST[1..MAX_LEN] and BASE[1..MAX_LEN] constant arrays;
  - the SYMS ROM.
- Default verification table, lengths 1–4, one symbol each:
  - A = 0x00 "0";
  - B = 0x01 "10";
  - C = 0x02 "110";
  - D = 0x03 "1110";
  - "1111" is invalid, with MAX_LEN = 4 in test.
- Sub-module huffman_canon_lookup: combinational (c, l) → (hit, symbol).

## Test plan
- Byte 0x00, out_ready = 1 → eight symbols 0x00 with out_len 1, on consecutive cycles starting 2 cycles after accept.
- Byte 0x58 → 0x00, 0x01, 0x02, 0x00, 0x00 with out_len 1, 2, 3, 1, 1.
- Bytes 0x01, 0xC0 → seven 0x00, then 0x03 (len 4, codeword spans the byte boundary), then five 0x00; 13 symbols total.
- Byte 0xF0 → err = 1 on the 4th bit step, no symbol emitted, and in_ready stays 0 thereafter.
- Byte 0x58 with out_ready = 0 for 10 cycles after the first out_valid → out_sym = 0x00 held, and bcnt frozen. Releasing out_ready gives the remaining sequence with no loss.
- Assert rst after 3 bits of 0xEE → all outputs 0 immediately, and in_ready = 1 after release. A following byte 0x00 decodes eight 0x00.
